tick_frame_ctrl: RTL and testbench
==================================

Name: tick_frame_ctrl

Overview:
- Sequencing controller between the SPI byte receiver and the feature-extraction engine.
- Consumes the valid/ready byte stream from the SPI receiver and hunts for a sync byte.
- Assembles fixed-length tick frames, verifies the checksum and emits one decoded tick record per good frame over a valid/ready handshake.
- Applies backpressure to the SPI receiver while a tick is pending, and keeps good-frame and error counters for debug readout.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1024, max clk cycles allowed between accepted bytes inside a frame (min 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  8  byte from SPI receiver.
- in_val  in  1  in_data valid.
- in_rdy  out  1  controller can accept a byte.
- frame_abort  in  1  one-cycle pulse on chip-select deassert (end of SPI transaction).
- tick_type  out  2  00 bid update, 01 ask update, 10 trade, 11 book reset.
- tick_price  out  16  price, big-endian assembled.
- tick_qty  out  16  quantity, big-endian assembled.
- tick_val  out  1  tick record valid.
- tick_rdy  in  1  feature engine accepts tick.
- frm_cnt  out  8  good frames emitted, saturating.
- err_cnt  out  8  dropped frames, saturating.

Behaviour:
- Frame format (byte order): SYNC, OPC, PRC_H, PRC_L, QTY_H, QTY_L, CHK.
  - OPC[7:6] is the type; OPC[5:0] must be zero.
  - CHK = OPC ^ PRC_H ^ PRC_L ^ QTY_H ^ QTY_L.
- A byte is accepted on any rising clk edge with in_val && in_rdy.
- in_rdy = 1 in every state except OUT.
- Accepted bytes are registered, so tick_val rises the cycle after CHK is accepted.
- States: HUNT, OPC, PH, PL, QH, QL, CHK, OUT.
- HUNT:
  - Accepted byte == SYNC_BYTE -> OPC.
  - Any other byte is discarded silently; no error is counted.
- OPC:
  - Accepted byte with [5:0] != 0 -> err_cnt++, HUNT.
  - Otherwise latch type and XOR accumulator, then -> PH.
- PH, PL, QH, QL: latch byte into the price/qty shadow register, update the accumulator, advance to the next state.
- CHK:
  - Byte == accumulator -> load tick_* outputs from shadow, set tick_val = 1, frm_cnt++, -> OUT.
  - Mismatch -> err_cnt++, HUNT.
- OUT:
  - tick_val and tick_* are held stable until tick_rdy = 1.
  - On the handshake cycle, tick_val clears next cycle and the state returns to HUNT.
  - tick_rdy already high on entry -> tick_val is high for exactly 1 cycle.
- Timeout:
  - An idle counter clears on every accepted byte and on entering OPC.
  - It counts while in OPC..CHK with no accepted byte.
  - Reaching TIMEOUT_CYC-1 -> err_cnt++, HUNT.
  - The counter is inactive in HUNT and OUT.
- frame_abort:
  - In OPC..CHK -> err_cnt++, HUNT.
  - It has priority over a byte accepted in the same cycle; that byte is consumed and discarded.
  - It is ignored in HUNT and OUT.
- A SYNC_BYTE value appearing mid-frame is treated as data; there is no resync.
- Counters saturate at 8'hFF. At most one increment per cycle, because error and good-frame events are mutually exclusive.
- Reset (asynchronous, any state):
  - State -> HUNT.
  - tick_val = 0, tick_type = 0, tick_price = 0, tick_qty = 0, frm_cnt = 0, err_cnt = 0.
  - in_rdy = 1 after reset.
  - Reset asserted mid-frame or mid-OUT discards the partial frame or the pending tick; no counter is changed.

Test Plan:
- Good bid frame A5 00 12 34 00 0A 2C (back-to-back in_val) -> tick_val 1 cycle after CHK; type 00, price 16'h1234, qty 16'h000A; frm_cnt 1; err_cnt 0.
- Trade frame A5 80 01 00 00 05 84 with tick_rdy held low 5 cycles -> in_rdy 0 and tick_* stable during the stall; the byte A5 presented meanwhile is not accepted; after tick_rdy=1, state is HUNT and that A5 is accepted next cycle.
- Bad checksum A5 00 12 34 00 0A 2D -> no tick_val; err_cnt 1; the following good frame decodes normally.
- Reserved opcode A5 41, plus the noise bytes 00 FF 3C before the sync byte -> err_cnt 1 from the opcode only; the noise bytes count no error.
- Stall after PRC_L for TIMEOUT_CYC cycles -> err_cnt 1, HUNT. Separately, frame_abort in the same cycle as QTY_H -> err_cnt 1, byte dropped.
- 300 bad-checksum frames -> err_cnt saturates at 8'hFF. Reset asserted mid-frame -> all outputs 0 immediately; the next good frame gives frm_cnt 1.

Source files
------------

// File: rtl/tick_frame_ctrl.sv
// tick_frame_ctrl: hunts for a sync byte, assembles 7-byte tick frames, verifies the XOR checksum,
// and presents one decoded tick per good frame, with saturating good/error counters.
module tick_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic        frame_abort,
  output logic [1:0]  tick_type,
  output logic [15:0] tick_price,
  output logic [15:0] tick_qty,
  output logic        tick_val,
  input  logic        tick_rdy,
  output logic [7:0]  frm_cnt,
  output logic [7:0]  err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {S_HUNT, S_OPC, S_PH, S_PL, S_QH, S_QL, S_CHK, S_OUT} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [1:0]    typ_q, typ_d;
  logic [15:0]   prc_q, prc_d, qty_q, qty_d;
  logic [7:0]    xacc_q, xacc_d;
  logic [1:0]    tick_type_q, tick_type_d;
  logic [15:0]   tick_price_q, tick_price_d, tick_qty_q, tick_qty_d;
  logic          tick_val_q, tick_val_d;
  logic [7:0]    frm_q, frm_d, err_q, err_d;
  logic          accept, in_frame, kill, bump_err, bump_frm;
  assign in_rdy     = state_q != S_OUT;
  assign accept     = in_val && in_rdy;
  assign in_frame   = state_q != S_HUNT && state_q != S_OUT;
  // abort wins over a same-cycle byte; timeout only fires on a cycle with no byte
  assign kill       = in_frame && (frame_abort || (!accept && idle_q == IDLE_MAX));
  assign tick_type  = tick_type_q;
  assign tick_price = tick_price_q;
  assign tick_qty   = tick_qty_q;
  assign tick_val   = tick_val_q;
  assign frm_cnt    = frm_q;
  assign err_cnt    = err_q;
  always_comb begin
    state_d      = state_q;
    typ_d        = typ_q;
    prc_d        = prc_q;
    qty_d        = qty_q;
    xacc_d       = xacc_q;
    tick_type_d  = tick_type_q;
    tick_price_d = tick_price_q;
    tick_qty_d   = tick_qty_q;
    tick_val_d   = tick_val_q;
    bump_err     = 1'b0;
    bump_frm     = 1'b0;
    idle_d       = (in_frame && !accept && !kill) ? idle_q + 1'b1 : '0;
    if (kill) begin
      state_d  = S_HUNT;
      bump_err = 1'b1;
    end else begin
      case (state_q)
        S_HUNT: if (accept && in_data == SYNC_BYTE) state_d = S_OPC;
        S_OPC: if (accept) begin
          if (in_data[5:0] != '0) begin
            bump_err = 1'b1;
            state_d  = S_HUNT;
          end else begin
            typ_d   = in_data[7:6];
            xacc_d  = in_data;
            state_d = S_PH;
          end
        end
        S_PH: if (accept) begin
          prc_d[15:8] = in_data;
          xacc_d      = xacc_q ^ in_data;
          state_d     = S_PL;
        end
        S_PL: if (accept) begin
          prc_d[7:0] = in_data;
          xacc_d     = xacc_q ^ in_data;
          state_d    = S_QH;
        end
        S_QH: if (accept) begin
          qty_d[15:8] = in_data;
          xacc_d      = xacc_q ^ in_data;
          state_d     = S_QL;
        end
        S_QL: if (accept) begin
          qty_d[7:0] = in_data;
          xacc_d     = xacc_q ^ in_data;
          state_d    = S_CHK;
        end
        S_CHK: if (accept) begin
          if (in_data == xacc_q) begin
            tick_type_d  = typ_q;
            tick_price_d = prc_q;
            tick_qty_d   = qty_q;
            tick_val_d   = 1'b1;
            bump_frm     = 1'b1;
            state_d      = S_OUT;
          end else begin
            bump_err = 1'b1;
            state_d  = S_HUNT;
          end
        end
        S_OUT: if (tick_rdy) begin
          tick_val_d = 1'b0;
          state_d    = S_HUNT;
        end
        default: state_d = S_HUNT;
      endcase
    end
    frm_d = (bump_frm && frm_q != 8'hFF) ? frm_q + 8'd1 : frm_q;
    err_d = (bump_err && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_HUNT;
      idle_q       <= '0;
      typ_q        <= '0;
      prc_q        <= '0;
      qty_q        <= '0;
      xacc_q       <= '0;
      tick_type_q  <= '0;
      tick_price_q <= '0;
      tick_qty_q   <= '0;
      tick_val_q   <= 1'b0;
      frm_q        <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      typ_q        <= typ_d;
      prc_q        <= prc_d;
      qty_q        <= qty_d;
      xacc_q       <= xacc_d;
      tick_type_q  <= tick_type_d;
      tick_price_q <= tick_price_d;
      tick_qty_q   <= tick_qty_d;
      tick_val_q   <= tick_val_d;
      frm_q        <= frm_d;
      err_q        <= err_d;
    end
  end
endmodule

// File: tb/tb_tick_frame_ctrl.sv
// tb_tick_frame_ctrl: directed and randomized frame traffic checked against a frame-level expectation model.
module tb_tick_frame_ctrl;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] in_data = '0;
  logic in_val = 1'b0, frame_abort = 1'b0, tick_rdy = 1'b0;
  logic in_rdy, tick_val;
  logic [1:0] tick_type;
  logic [15:0] tick_price, tick_qty;
  logic [7:0] frm_cnt, err_cnt;
  int checks = 0, failures = 0;
  int exp_frm = 0, exp_err = 0;
  tick_frame_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
    .frame_abort(frame_abort), .tick_type(tick_type), .tick_price(tick_price),
    .tick_qty(tick_qty), .tick_val(tick_val), .tick_rdy(tick_rdy),
    .frm_cnt(frm_cnt), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_val = 1'b1;
    in_data = b;
    while (!in_rdy && n < 20) begin
      step();
      n++;
    end
    if (n == 20) begin
      checks++;
      failures++;
      $error("FAIL send_wait observed=in_rdy_low expected=accept");
    end
    step();
  endtask
  task automatic send_frame(input logic [1:0] t, input logic [15:0] p, input logic [15:0] q, input bit corrupt);
    logic [7:0] opc, ck;
    opc = {t, 6'd0};
    ck = opc ^ p[15:8] ^ p[7:0] ^ q[15:8] ^ q[7:0] ^ {7'd0, corrupt};
    send(SYNC); send(opc); send(p[15:8]); send(p[7:0]); send(q[15:8]); send(q[7:0]); send(ck);
    in_val = 1'b0;
  endtask
  task automatic check_counts(input string tag);
    chk({tag, "_frm"}, frm_cnt, exp_frm);
    chk({tag, "_err"}, err_cnt, exp_err);
  endtask
  task automatic expect_tick(input logic [1:0] t, input logic [15:0] p, input logic [15:0] q, input int hold);
    chk("tick_val", tick_val, 1);
    chk("tick_type", tick_type, t);
    chk("tick_price", tick_price, p);
    chk("tick_qty", tick_qty, q);
    check_counts("tick");
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_val", tick_val, 1);
      chk("hold_in_rdy", in_rdy, 0);
      chk("hold_price", tick_price, p);
      chk("hold_qty", tick_qty, q);
    end
    tick_rdy = 1'b1;
    step();
    tick_rdy = 1'b0;
    chk("tick_clear", tick_val, 0);
    chk("in_rdy_back", in_rdy, 1);
  endtask
  task automatic good_frame(input logic [1:0] t, input logic [15:0] p, input logic [15:0] q, input int hold);
    if (hold < 0) tick_rdy = 1'b1;
    send_frame(t, p, q, 1'b0);
    if (exp_frm < 255) exp_frm++;
    expect_tick(t, p, q, hold);
  endtask
  task automatic bad_chk_frame(input logic [1:0] t, input logic [15:0] p, input logic [15:0] q);
    send_frame(t, p, q, 1'b1);
    if (exp_err < 255) exp_err++;
    chk("badchk_val", tick_val, 0);
    check_counts("badchk");
  endtask
  task automatic noise(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      while (b == SYNC) b = 8'($urandom);
      send(b);
    end
    in_val = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_val"}, tick_val, 0);
    chk({tag, "_type"}, tick_type, 0);
    chk({tag, "_price"}, tick_price, 0);
    chk({tag, "_qty"}, tick_qty, 0);
    chk({tag, "_frm"}, frm_cnt, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_in_rdy"}, in_rdy, 1);
  endtask
  initial begin
    logic [1:0] t;
    logic [7:0] b;
    logic [15:0] p, q;
    int kind;
    rst = 1'b1;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    // good bid frame, tick_rdy already high: tick_val lasts one cycle
    tick_rdy = 1'b1;
    send(8'hA5); send(8'h00); send(8'h12); send(8'h34); send(8'h00); send(8'h0A); send(8'h2C);
    in_val = 1'b0;
    exp_frm = 1;
    chk("bid_val", tick_val, 1);
    chk("bid_type", tick_type, 0);
    chk("bid_price", tick_price, 16'h1234);
    chk("bid_qty", tick_qty, 16'h000A);
    check_counts("bid");
    step();
    tick_rdy = 1'b0;
    chk("bid_one_cycle", tick_val, 0);
    // trade frame stalled 5 cycles with a pending A5 that must wait
    send(8'hA5); send(8'h80); send(8'h01); send(8'h00); send(8'h00); send(8'h05); send(8'h84);
    exp_frm++;
    in_data = 8'hA5;
    chk("trade_val", tick_val, 1);
    chk("trade_type", tick_type, 2);
    repeat (5) begin
      step();
      chk("stall_in_rdy", in_rdy, 0);
      chk("stall_val", tick_val, 1);
      chk("stall_type", tick_type, 2);
      chk("stall_price", tick_price, 16'h0100);
      chk("stall_qty", tick_qty, 16'h0005);
    end
    tick_rdy = 1'b1;
    step();
    tick_rdy = 1'b0;
    chk("trade_clear", tick_val, 0);
    chk("trade_in_rdy", in_rdy, 1);
    step();
    send(8'h00); send(8'h12); send(8'h34); send(8'h00); send(8'h0A); send(8'h2C);
    in_val = 1'b0;
    exp_frm++;
    expect_tick(2'd0, 16'h1234, 16'h000A, 0);
    // bad checksum then a normal frame
    send(8'hA5); send(8'h00); send(8'h12); send(8'h34); send(8'h00); send(8'h0A); send(8'h2D);
    in_val = 1'b0;
    exp_err++;
    chk("badchk_no_tick", tick_val, 0);
    check_counts("badchk_dir");
    good_frame(2'd1, 16'hBEEF, 16'h0102, 2);
    // noise is silent, reserved opcode is an error
    send(8'h00); send(8'hFF); send(8'h3C);
    in_val = 1'b0;
    check_counts("noise");
    send(8'hA5); send(8'h41);
    in_val = 1'b0;
    exp_err++;
    check_counts("resv_opc");
    // sync value inside a frame is plain data
    good_frame(2'd3, 16'hA5A5, 16'h00A5, 1);
    // timeout after PRC_L, then the trailing bytes are hunted and discarded
    send(8'hA5); send(8'h00); send(8'h12); send(8'h34);
    in_val = 1'b0;
    repeat (TO + 2) step();
    exp_err++;
    check_counts("timeout");
    send(8'h00); send(8'h0A); send(8'h2C);
    in_val = 1'b0;
    chk("timeout_no_tick", tick_val, 0);
    check_counts("timeout_tail");
    // a stall just short of the timeout keeps the frame alive
    send(8'hA5); send(8'h00); send(8'h12); send(8'h34);
    in_val = 1'b0;
    repeat (TO - 2) step();
    send(8'h00); send(8'h0A); send(8'h2C);
    in_val = 1'b0;
    exp_frm++;
    expect_tick(2'd0, 16'h1234, 16'h000A, 0);
    // abort together with QTY_H
    send(8'hA5); send(8'h80); send(8'h01); send(8'h00);
    in_data = 8'h00;
    frame_abort = 1'b1;
    step();
    frame_abort = 1'b0;
    in_val = 1'b0;
    exp_err++;
    check_counts("abort");
    send(8'h05); send(8'h84);
    in_val = 1'b0;
    chk("abort_no_tick", tick_val, 0);
    check_counts("abort_tail");
    frame_abort = 1'b1;
    step();
    frame_abort = 1'b0;
    check_counts("abort_hunt");
    send_frame(2'd2, 16'h0042, 16'h0007, 1'b0);
    exp_frm++;
    frame_abort = 1'b1;
    step();
    frame_abort = 1'b0;
    expect_tick(2'd2, 16'h0042, 16'h0007, 1);
    // randomized traffic
    repeat (40) begin
      noise($urandom_range(0, 3));
      t = 2'($urandom);
      p = 16'($urandom);
      q = 16'($urandom);
      kind = $urandom_range(0, 3);
      if (kind < 2) good_frame(t, p, q, $urandom_range(0, 3));
      else if (kind == 2) bad_chk_frame(t, p, q);
      else begin
        b = {t, 6'($urandom_range(1, 63))};
        send(SYNC); send(b);
        in_val = 1'b0;
        if (exp_err < 255) exp_err++;
        check_counts("rand_opc");
      end
    end
    // saturation of both counters
    repeat (300) send_frame(2'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    exp_err = 255;
    check_counts("err_sat");
    repeat (260) good_frame(2'($urandom), 16'($urandom), 16'($urandom), -1);
    tick_rdy = 1'b0;
    chk("frm_sat", frm_cnt, 8'hFF);
    chk("err_still_sat", err_cnt, 8'hFF);
    // asynchronous reset while a tick is pending, then mid-frame
    send_frame(2'd1, 16'h1111, 16'h2222, 1'b0);
    chk("pre_rst_val", tick_val, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_out");
    step();
    rst = 1'b0;
    step();
    send(8'hA5); send(8'h00); send(8'h12);
    in_val = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    step();
    rst = 1'b0;
    step();
    exp_frm = 0;
    exp_err = 0;
    good_frame(2'd0, 16'h1234, 16'h000A, 0);
    chk("post_rst_frm", frm_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
